cpu_snapshot_scheduler: RTL and testbench

//  Sequences a once-per-frame coherent snapshot of CPU state for the VGA debug display.
//  On each v_sync falling edge it walks the one-hot content_enable_out mux over all CPU

---
 rtl/cpu_snapshot_scheduler.sv | 134 +++++++++++++
 tb/tb_cpu_snapshot_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_snapshot_scheduler.sv
// Once-per-frame CPU/memory snapshot sequencer for the VGA debug view.
// Captures into one bank of a double-buffered shadow store while the pixel side reads the other.
module cpu_snapshot_scheduler #(
  parameter int DATA_WIDTH           = 16,
  parameter int CPU_ELEMENTS         = 10,
  parameter int MEMORY_ADDRESS_WIDTH = 11,
  parameter int MEM_WORDS            = 16,
  parameter logic [MEMORY_ADDRESS_WIDTH-1:0] MEM_BASE = '0,
  parameter int SETTLE_CYCLES        = 1,
  parameter int READ_LATENCY         = 1,
  localparam int RIW = (CPU_ELEMENTS > 1) ? $clog2(CPU_ELEMENTS) : 1,
  localparam int MIW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic                            clock_in,
  input  logic                            reset_in,
  input  logic                            v_sync_in,
  input  logic [DATA_WIDTH-1:0]           cpu_content_in,
  input  logic [DATA_WIDTH-1:0]           instruction_memory_in,
  input  logic [DATA_WIDTH-1:0]           data_memory_in,
  output logic [CPU_ELEMENTS-1:0]         content_enable_out,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] instruction_address_out,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] data_address_out,
  input  logic [RIW-1:0]                  reg_index_in,
  input  logic [MIW-1:0]                  mem_index_in,
  output logic [DATA_WIDTH-1:0]           reg_value_out,
  output logic [DATA_WIDTH-1:0]           instr_value_out,
  output logic [DATA_WIDTH-1:0]           data_value_out,
  output logic                            busy_out,
  output logic                            snapshot_valid_out,
  output logic                            overrun_out
);

  localparam int IW   = (RIW > MIW) ? RIW : MIW;
  localparam int HMAX = (SETTLE_CYCLES > READ_LATENCY) ? SETTLE_CYCLES : READ_LATENCY;
  localparam int HW   = $clog2(HMAX + 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REG  = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_SWAP = 2'd3;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [HW-1:0] hold;
  logic          vs_d;
  logic          disp;
  logic          cap;
  logic          trigger;

  logic [1:0][CPU_ELEMENTS-1:0][DATA_WIDTH-1:0] regs;
  logic [1:0][MEM_WORDS-1:0][DATA_WIDTH-1:0]    instr;
  logic [1:0][MEM_WORDS-1:0][DATA_WIDTH-1:0]    data;

  assign trigger = vs_d & ~v_sync_in;
  assign cap     = ~disp;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state              <= S_IDLE;
      idx                <= '0;
      hold               <= '0;
      vs_d               <= 1'b1;
      disp               <= 1'b0;
      snapshot_valid_out <= 1'b0;
      overrun_out        <= 1'b0;
      regs               <= '0;
      instr              <= '0;
      data               <= '0;
    end else begin
      vs_d <= v_sync_in;
      // Any fall outside IDLE (including the SWAP cycle) is dropped and flagged.
      if (trigger && state != S_IDLE) overrun_out <= 1'b1;
      case (state)
        S_IDLE: if (trigger) begin
          state <= S_REG;
          idx   <= '0;
          hold  <= '0;
        end
        S_REG: if (hold == HW'(SETTLE_CYCLES)) begin
          regs[cap][idx[RIW-1:0]] <= cpu_content_in;
          hold <= '0;
          if (idx == IW'(CPU_ELEMENTS - 1)) begin
            idx   <= '0;
            state <= S_MEM;
          end else begin
            idx <= idx + IW'(1);
          end
        end else begin
          hold <= hold + HW'(1);
        end
        S_MEM: if (hold == HW'(READ_LATENCY)) begin
          instr[cap][idx[MIW-1:0]] <= instruction_memory_in;
          data[cap][idx[MIW-1:0]]  <= data_memory_in;
          hold <= '0;
          if (idx == IW'(MEM_WORDS - 1)) begin
            idx   <= '0;
            state <= S_SWAP;
          end else begin
            idx <= idx + IW'(1);
          end
        end else begin
          hold <= hold + HW'(1);
        end
        default: begin
          disp               <= ~disp;
          snapshot_valid_out <= 1'b1;
          state              <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_out           = (state != S_IDLE);
  assign content_enable_out = (state == S_REG) ? (CPU_ELEMENTS'(1) << idx) : '0;

  // Address wraps naturally at the address width.
  always_comb begin
    instruction_address_out = MEM_BASE;
    if (state == S_MEM) instruction_address_out = MEM_BASE + MEMORY_ADDRESS_WIDTH'(idx);
  end
  assign data_address_out = instruction_address_out;

  always_comb begin
    reg_value_out   = '0;
    instr_value_out = '0;
    data_value_out  = '0;
    if (32'(reg_index_in) < CPU_ELEMENTS) reg_value_out = regs[disp][reg_index_in];
    if (32'(mem_index_in) < MEM_WORDS) begin
      instr_value_out = instr[disp][mem_index_in];
      data_value_out  = data[disp][mem_index_in];
    end
  end

endmodule

// File: tb/tb_cpu_snapshot_scheduler.sv
// Randomized bench for cpu_snapshot_scheduler: two instances (base 0 and a wrapping base)
// checked every cycle against a frame-level reference model.
module tb_cpu_snapshot_scheduler;
  localparam int NE  = 10;
  localparam int NW  = 16;
  localparam int DUR = 2*NE + 2*NW + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic vsync = 1'b1;
  logic [3:0] ridx = '0;
  logic [3:0] midx = '0;
  always #5 clk = ~clk;

  logic [NE-1:0][15:0] fv;
  logic [15:0] mem_i [2048];
  logic [15:0] mem_d [2048];
  logic [10:0] base [2];

  logic [9:0]  en [2];
  logic [10:0] ia [2];
  logic [10:0] da [2];
  logic [15:0] cpu [2];
  logic [15:0] im [2];
  logic [15:0] dm [2];
  logic [15:0] rv [2];
  logic [15:0] iv [2];
  logic [15:0] dv [2];
  logic        busy [2];
  logic        valid [2];
  logic        ovr [2];

  always_comb begin
    for (int j = 0; j < 2; j++) begin
      cpu[j] = '0;
      for (int i = 0; i < NE; i++) if (en[j][i]) cpu[j] = cpu[j] | fv[i];
      im[j] = mem_i[ia[j]];
      dm[j] = mem_d[da[j]];
    end
  end

  cpu_snapshot_scheduler dut (
    .clock_in(clk), .reset_in(rst), .v_sync_in(vsync),
    .cpu_content_in(cpu[0]), .instruction_memory_in(im[0]), .data_memory_in(dm[0]),
    .content_enable_out(en[0]), .instruction_address_out(ia[0]), .data_address_out(da[0]),
    .reg_index_in(ridx), .mem_index_in(midx),
    .reg_value_out(rv[0]), .instr_value_out(iv[0]), .data_value_out(dv[0]),
    .busy_out(busy[0]), .snapshot_valid_out(valid[0]), .overrun_out(ovr[0]));

  cpu_snapshot_scheduler #(.MEM_BASE(11'h7F8)) dutw (
    .clock_in(clk), .reset_in(rst), .v_sync_in(vsync),
    .cpu_content_in(cpu[1]), .instruction_memory_in(im[1]), .data_memory_in(dm[1]),
    .content_enable_out(en[1]), .instruction_address_out(ia[1]), .data_address_out(da[1]),
    .reg_index_in(ridx), .mem_index_in(midx),
    .reg_value_out(rv[1]), .instr_value_out(iv[1]), .data_value_out(dv[1]),
    .busy_out(busy[1]), .snapshot_valid_out(valid[1]), .overrun_out(ovr[1]));

  // Reference model: remaining capture cycles plus per-instance shown/pending snapshots.
  int  n_cmp = 0;
  int  n_err = 0;
  int  bl;
  bit  vs_prev, m_valid, m_ovr;
  logic [15:0] dreg [2][NE];
  logic [15:0] dins [2][NW];
  logic [15:0] ddat [2][NW];
  logic [15:0] preg [2][NE];
  logic [15:0] pins [2][NW];
  logic [15:0] pdat [2][NW];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    bl = 0; vs_prev = 1'b1; m_valid = 1'b0; m_ovr = 1'b0;
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < NE; i++) dreg[j][i] = '0;
      for (int k = 0; k < NW; k++) begin dins[j][k] = '0; ddat[j][k] = '0; end
    end
  endtask

  task automatic model_edge();
    bit fall;
    fall = vs_prev && !vsync;
    vs_prev = vsync;
    if (bl > 0) begin
      if (fall) m_ovr = 1'b1;
      bl--;
      if (bl == 0) begin
        dreg = preg; dins = pins; ddat = pdat;
        m_valid = 1'b1;
      end
    end else if (fall) begin
      bl = DUR;
      for (int j = 0; j < 2; j++) begin
        for (int i = 0; i < NE; i++) preg[j][i] = fv[i];
        for (int k = 0; k < NW; k++) begin
          pins[j][k] = mem_i[(int'(base[j]) + k) % 2048];
          pdat[j][k] = mem_d[(int'(base[j]) + k) % 2048];
        end
      end
    end
  endtask

  task automatic check_all();
    int c;
    logic [9:0]  e_en;
    logic [10:0] e_a;
    logic [15:0] e_rv;
    c = DUR - bl;
    for (int j = 0; j < 2; j++) begin
      e_en = '0;
      e_a  = base[j];
      if (bl > 0) begin
        if (c < 2*NE) e_en[c/2] = 1'b1;
        else if (c < 2*NE + 2*NW) e_a = base[j] + 11'((c - 2*NE) / 2);
      end
      e_rv = '0;
      if (ridx < NE) e_rv = dreg[j][ridx];
      chk($sformatf("en%0d", j), en[j], e_en);
      chk($sformatf("onehot%0d", j), $onehot0(en[j]), 1);
      chk($sformatf("ia%0d", j), ia[j], e_a);
      chk($sformatf("da%0d", j), da[j], e_a);
      chk($sformatf("busy%0d", j), busy[j], bl > 0);
      chk($sformatf("valid%0d", j), valid[j], m_valid);
      chk($sformatf("ovr%0d", j), ovr[j], m_ovr);
      chk($sformatf("rv%0d", j), rv[j], e_rv);
      chk($sformatf("iv%0d", j), iv[j], dins[j][midx]);
      chk($sformatf("dv%0d", j), dv[j], ddat[j][midx]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Called at a negedge: asserts reset mid-cycle and checks the immediate effect.
  task automatic do_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic vfall();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
  endtask

  int nb;

  initial begin
    base[0] = 11'h000;
    base[1] = 11'h7F8;
    for (int a = 0; a < 2048; a++) begin
      mem_i[a] = 16'(2*a);
      mem_d[a] = 16'(2*a + 1);
    end
    for (int i = 0; i < NE; i++) fv[i] = 16'h0100 + 16'(i);
    model_reset();

    @(negedge clk);
    do_reset();
    repeat (3) step();

    // Frame 1: known pattern
    ridx = 4'd3; midx = 4'd5;
    nb = 0;
    vfall();
    if (busy[0]) nb++;
    for (int n = 0; n < 60; n++) begin
      step();
      if (busy[0]) nb++;
    end
    chk("busy_len", nb, DUR);
    chk("f1_reg3", rv[0], 16'h0103);
    chk("f1_ins5", iv[0], 16'h000A);
    chk("f1_dat5", dv[0], 16'h000B);
    chk("f1_valid", valid[0], 1);

    // Frame 2: new CPU values appear only after SWAP
    for (int i = 0; i < NE; i++) fv[i] = 16'h0200 + 16'(i);
    vfall();
    for (int n = 0; n < 51; n++) step();
    chk("f2_before_swap", rv[0], 16'h0103);
    for (int n = 0; n < 5; n++) step();
    chk("f2_reg3", rv[0], 16'h0203);

    // Overrun: second fall 20 cycles into the capture
    vfall();
    for (int n = 0; n < 19; n++) step();
    vfall();
    for (int n = 0; n < 45; n++) step();
    chk("ovr_set", ovr[0], 1);

    // Abort at capture cycle 30, then a clean capture
    for (int i = 0; i < NE; i++) fv[i] = 16'h0300 + 16'(i);
    vfall();
    for (int n = 0; n < 29; n++) step();
    do_reset();
    chk("abort_ovr", ovr[0], 0);
    repeat (2) step();
    vfall();
    for (int n = 0; n < 60; n++) step();
    chk("abort_recap", rv[1], 16'h0303);

    // Random phase
    for (int n = 0; n < 6000; n++) begin
      ridx = 4'($urandom_range(0, 15));
      midx = 4'($urandom_range(0, 15));
      if (vsync) vsync = ($urandom_range(0, 39) != 0);
      else       vsync = ($urandom_range(0, 2) == 0);
      if (bl == 0 && $urandom_range(0, 19) == 0) begin
        for (int i = 0; i < NE; i++) fv[i] = 16'($urandom);
        for (int k = 0; k < 16; k++) begin
          mem_i[k] = 16'($urandom); mem_d[k] = 16'($urandom);
          mem_i[2032 + k] = 16'($urandom); mem_d[2032 + k] = 16'($urandom);
        end
      end
      if (n == 3000) do_reset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
